// File: rtl/cv_hdmi_pkg.sv
// Shared HDMI period codes and control/guard symbols used by the period scheduler
// and the downstream TMDS encode/mux stage.
package cv_hdmi_pkg;

    typedef enum logic [1:0] {
        PERIOD_CTRL  = 2'd0,
        PERIOD_PRE   = 2'd1,
        PERIOD_GUARD = 2'd2,
        PERIOD_VIDEO = 2'd3
    } period_e;

    // {CTL3,CTL2,CTL1,CTL0} announcing a video data period
    localparam logic [3:0] CTL_PREAMBLE_VIDEO = 4'b0001;

    localparam logic [9:0] GUARD_WORD_BR = 10'b10_1100_1100;
    localparam logic [9:0] GUARD_WORD_G  = 10'b01_0011_0011;

    // Channel index: 0 = blue, 1 = green, 2 = red
    function automatic logic [9:0] guard_word(input logic [1:0] chan);
        return (chan == 2'd1) ? GUARD_WORD_G : GUARD_WORD_BR;
    endfunction

endpackage

// File: rtl/cv_delay_line.sv
// Fixed-length shift register; dout is din delayed by D clocks, cleared on reset.
module cv_delay_line #(
    parameter int W = 3,
    parameter int D = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    genvar gi;
    generate
        for (gi = 0; gi < D; gi++) begin : g_stage
            logic [W-1:0] tap_d;
            logic [W-1:0] tap_q;

            if (gi == 0) begin : g_first
                assign tap_d = din;
            end else begin : g_rest
                assign tap_d = g_stage[gi-1].tap_q;
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    tap_q <= '0;
                end else begin
                    tap_q <= tap_d;
                end
            end
        end
    endgenerate

    assign dout = g_stage[D-1].tap_q;

endmodule

// File: rtl/cv_period_sched.sv
// HDMI period scheduler: delays {de,hs,vs} so a video preamble and leading guard
// band can be slotted in ahead of each active run, and flags too-short blanking.
module cv_period_sched
    import cv_hdmi_pkg::*;
#(
    parameter int PRE_LEN   = 8,
    parameter int GUARD_LEN = 2,
    parameter int MIN_CTRL  = 12
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       hdmi_en,
    input  logic       de_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       err_clr,
    output logic [1:0] period,
    output logic       hs_out,
    output logic       vs_out,
    output logic [1:0] ctrl_b,
    output logic [1:0] ctrl_g,
    output logic [1:0] ctrl_r,
    output logic       err_short_ctrl
);

    localparam int DLY     = PRE_LEN + GUARD_LEN;
    localparam int LOW_SAT = MIN_CTRL + GUARD_LEN;
    localparam int CNT_MAX = (PRE_LEN > GUARD_LEN) ? PRE_LEN : GUARD_LEN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int LOW_W   = $clog2(LOW_SAT + 1);

    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_LEN - 1);
    localparam logic [LOW_W-1:0] LOW_SAT_V  = LOW_W'(LOW_SAT);

    logic             de_tap, hs_tap, vs_tap;
    logic             de_prev_d, de_prev_q;
    logic [LOW_W-1:0] low_cnt_d, low_cnt_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    period_e          period_d, period_q;
    logic             hs_out_d, hs_out_q;
    logic             vs_out_d, vs_out_q;
    logic             err_d, err_q;
    logic             rise;
    logic             err_set;

    cv_delay_line #(
        .W (3),
        .D (DLY)
    ) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({de_in, hs_in, vs_in}),
        .dout    ({de_tap, hs_tap, vs_tap})
    );

    assign rise    = de_in & ~de_prev_q;
    // A blanking run shorter than the output control period needs is flagged at its end
    assign err_set = rise & (low_cnt_q < LOW_SAT_V);

    always_comb begin
        de_prev_d = de_in;
        hs_out_d  = hs_tap;
        vs_out_d  = vs_tap;
        low_cnt_d = low_cnt_q;
        err_d     = err_q;

        if (de_in) begin
            low_cnt_d = '0;
        end else if (low_cnt_q != LOW_SAT_V) begin
            low_cnt_d = low_cnt_q + 1'b1;
        end

        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        case (period_q)
            PERIOD_CTRL: begin
                if (de_tap) begin
                    period_d = PERIOD_VIDEO;
                end else if (hdmi_en && rise) begin
                    period_d = PERIOD_PRE;
                    cnt_d    = '0;
                end
            end
            PERIOD_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    period_d = PERIOD_GUARD;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PERIOD_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    period_d = PERIOD_VIDEO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PERIOD_VIDEO: begin
                if (!de_tap) begin
                    period_d = PERIOD_CTRL;
                end
            end
            default: period_d = PERIOD_CTRL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_q  <= PERIOD_CTRL;
            cnt_q     <= '0;
            de_prev_q <= 1'b0;
            low_cnt_q <= LOW_SAT_V;
            hs_out_q  <= 1'b0;
            vs_out_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            de_prev_q <= de_prev_d;
            low_cnt_q <= low_cnt_d;
            hs_out_q  <= hs_out_d;
            vs_out_q  <= vs_out_d;
            err_q     <= err_d;
        end
    end

    assign period         = period_q;
    assign hs_out         = hs_out_q;
    assign vs_out         = vs_out_q;
    assign ctrl_b         = {vs_out_q, hs_out_q};
    assign ctrl_g         = (period_q == PERIOD_PRE) ? CTL_PREAMBLE_VIDEO[1:0] : 2'b00;
    assign ctrl_r         = (period_q == PERIOD_PRE) ? CTL_PREAMBLE_VIDEO[3:2] : 2'b00;
    assign err_short_ctrl = err_q;

endmodule

// File: tb/tb_cv_period_sched.sv
// Directed bench for cv_period_sched: each scenario plays a stimulus table, records
// the outputs per cycle, then compares against hand-derived cycle indices.
module tb_cv_period_sched;

    localparam logic [1:0] P_CTRL  = 2'd0;
    localparam logic [1:0] P_PRE   = 2'd1;
    localparam logic [1:0] P_GUARD = 2'd2;
    localparam logic [1:0] P_VIDEO = 2'd3;
    localparam int N = 1024;

    logic       clk = 1'b0;
    logic       reset_n, hdmi_en, de_in, hs_in, vs_in, err_clr;
    logic [1:0] period, ctrl_b, ctrl_g, ctrl_r;
    logic       hs_out, vs_out, err_short_ctrl;

    int errors = 0;
    int checks = 0;

    logic       s_de [N];
    logic       s_hs [N];
    logic       s_vs [N];
    logic       s_clr[N];
    logic [1:0] r_per[N];
    logic [1:0] r_b  [N];
    logic [1:0] r_g  [N];
    logic [1:0] r_r  [N];
    logic       r_err[N];

    always #5 clk = ~clk;

    cv_period_sched dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .hdmi_en        (hdmi_en),
        .de_in          (de_in),
        .hs_in          (hs_in),
        .vs_in          (vs_in),
        .err_clr        (err_clr),
        .period         (period),
        .hs_out         (hs_out),
        .vs_out         (vs_out),
        .ctrl_b         (ctrl_b),
        .ctrl_g         (ctrl_g),
        .ctrl_r         (ctrl_r),
        .err_short_ctrl (err_short_ctrl)
    );

    task automatic clear_stim();
        for (int i = 0; i < N; i++) begin
            s_de[i] = 1'b0; s_hs[i] = 1'b0; s_vs[i] = 1'b0; s_clr[i] = 1'b0;
        end
    endtask

    task automatic set_de(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) s_de[i] = 1'b1;
    endtask

    // Index i records outputs just after edge i, then drives stimulus i (sampled at edge i+1)
    task automatic play(input int len);
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            r_per[i] = period; r_b[i] = ctrl_b; r_g[i] = ctrl_g; r_r[i] = ctrl_r;
            r_err[i] = err_short_ctrl;
            de_in = s_de[i]; hs_in = s_hs[i]; vs_in = s_vs[i]; err_clr = s_clr[i];
        end
        de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0; err_clr = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; hdmi_en = 1'b1;
        de_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1; err_clr = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checks++; if (period !== P_CTRL) begin errors++; $display("FAIL reset_period: got %0d expected %0d", period, P_CTRL); end
        checks++; if (hs_out !== 1'b0) begin errors++; $display("FAIL reset_hs_out: got %0b expected 0", hs_out); end
        checks++; if (vs_out !== 1'b0) begin errors++; $display("FAIL reset_vs_out: got %0b expected 0", vs_out); end
        checks++; if (ctrl_b !== 2'b00) begin errors++; $display("FAIL reset_ctrl_b: got %0b expected 00", ctrl_b); end
        checks++; if (ctrl_g !== 2'b00) begin errors++; $display("FAIL reset_ctrl_g: got %0b expected 00", ctrl_g); end
        checks++; if (ctrl_r !== 2'b00) begin errors++; $display("FAIL reset_ctrl_r: got %0b expected 00", ctrl_r); end
        checks++; if (err_short_ctrl !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err_short_ctrl); end
        de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_nominal();
        int npre_g, nguard, nvid, first_vid, ng;
        clear_stim(); hdmi_en = 1'b1;
        set_de(160, 799);
        play(830);
        npre_g = 0; nguard = 0; nvid = 0; first_vid = -1; ng = 0;
        for (int i = 0; i < 830; i++) begin
            if (i >= 161 && i <= 168 && r_per[i] == P_PRE && r_g[i] == 2'b01) npre_g++;
            if (r_per[i] == P_GUARD) nguard++;
            if (r_per[i] == P_VIDEO) begin nvid++; if (first_vid < 0) first_vid = i; end
            if (r_g[i] != 2'b00) ng++;
        end
        checks++; if (r_per[160] !== P_CTRL) begin errors++; $display("FAIL nom_ctrl_before: got %0d expected %0d", r_per[160], P_CTRL); end
        checks++; if (npre_g != 8) begin errors++; $display("FAIL nom_preamble_len: got %0d expected 8", npre_g); end
        checks++; if (ng != 8) begin errors++; $display("FAIL nom_ctrl_g_cycles: got %0d expected 8", ng); end
        checks++; if (r_per[169] !== P_GUARD || r_per[170] !== P_GUARD || nguard != 2) begin errors++; $display("FAIL nom_guard: got %0d cycles expected 2 at 169..170", nguard); end
        checks++; if (first_vid != 171) begin errors++; $display("FAIL nom_first_video: got %0d expected 171", first_vid); end
        checks++; if (nvid != 640) begin errors++; $display("FAIL nom_video_len: got %0d expected 640", nvid); end
        checks++; if (r_per[811] !== P_CTRL) begin errors++; $display("FAIL nom_video_end: got %0d expected %0d", r_per[811], P_CTRL); end
        checks++; if (r_err[829] !== 1'b0) begin errors++; $display("FAIL nom_err: got %0b expected 0", r_err[829]); end
        $display("test_nominal done");
    endtask

    task automatic test_dvi();
        int npg, nvid, first_vid;
        apply_reset(); clear_stim(); hdmi_en = 1'b0;
        set_de(160, 799);
        play(830);
        npg = 0; nvid = 0; first_vid = -1;
        for (int i = 0; i < 830; i++) begin
            if (r_per[i] == P_PRE || r_per[i] == P_GUARD) npg++;
            if (r_per[i] == P_VIDEO) begin nvid++; if (first_vid < 0) first_vid = i; end
        end
        checks++; if (npg != 0) begin errors++; $display("FAIL dvi_no_pre_guard: got %0d cycles expected 0", npg); end
        checks++; if (first_vid != 171) begin errors++; $display("FAIL dvi_first_video: got %0d expected 171", first_vid); end
        checks++; if (nvid != 640) begin errors++; $display("FAIL dvi_video_len: got %0d expected 640", nvid); end
        checks++; if (r_err[829] !== 1'b0) begin errors++; $display("FAIL dvi_err: got %0b expected 0", r_err[829]); end
        $display("test_dvi done");
    endtask

    task automatic test_marginal();
        int run, first_vid;
        apply_reset(); clear_stim(); hdmi_en = 1'b1;
        set_de(20, 49);
        set_de(62, 91);
        play(120);
        run = 0;
        for (int i = 61; i < 120 && (r_per[i] == P_CTRL || r_per[i] == P_PRE); i++) run++;
        first_vid = -1;
        for (int i = 61; i < 120; i++) if (first_vid < 0 && r_per[i] == P_VIDEO) first_vid = i;
        checks++; if (r_per[60] !== P_VIDEO) begin errors++; $display("FAIL marg_run1_last: got %0d expected %0d", r_per[60], P_VIDEO); end
        checks++; if (run != 10) begin errors++; $display("FAIL marg_ctrl_run: got %0d expected 10", run); end
        checks++; if (r_per[63] !== P_PRE || r_per[71] !== P_GUARD) begin errors++; $display("FAIL marg_pre_guard: got %0d/%0d expected 1/2", r_per[63], r_per[71]); end
        checks++; if (first_vid != 73) begin errors++; $display("FAIL marg_first_video: got %0d expected 73", first_vid); end
        checks++; if (r_err[62] !== 1'b0) begin errors++; $display("FAIL marg_err_before: got %0b expected 0", r_err[62]); end
        checks++; if (r_err[63] !== 1'b1) begin errors++; $display("FAIL marg_err_set: got %0b expected 1", r_err[63]); end
        checks++; if (r_err[119] !== 1'b1) begin errors++; $display("FAIL marg_err_sticky: got %0b expected 1", r_err[119]); end
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        checks++; if (err_short_ctrl !== 1'b0) begin errors++; $display("FAIL marg_err_clr: got %0b expected 0", err_short_ctrl); end
        $display("test_marginal done");
    endtask

    task automatic test_short();
        int nctrl, npre, nvid;
        apply_reset(); clear_stim(); hdmi_en = 1'b1;
        set_de(20, 49);
        set_de(55, 84);
        s_clr[55] = 1'b1;
        play(120);
        nctrl = 0;
        for (int i = 61; i <= 65; i++) if (r_per[i] == P_CTRL) nctrl++;
        npre = 0; nvid = 0;
        for (int i = 0; i < 120; i++) begin
            if (r_per[i] == P_PRE) npre++;
            if (r_per[i] == P_VIDEO) nvid++;
        end
        checks++; if (r_per[60] !== P_VIDEO || r_per[66] !== P_VIDEO) begin errors++; $display("FAIL short_video_edges: got %0d/%0d expected 3/3", r_per[60], r_per[66]); end
        checks++; if (nctrl != 5) begin errors++; $display("FAIL short_ctrl_gap: got %0d expected 5", nctrl); end
        checks++; if (npre != 8) begin errors++; $display("FAIL short_no_second_pre: got %0d expected 8", npre); end
        checks++; if (nvid != 60) begin errors++; $display("FAIL short_video_total: got %0d expected 60", nvid); end
        checks++; if (r_err[55] !== 1'b0) begin errors++; $display("FAIL short_err_before: got %0b expected 0", r_err[55]); end
        checks++; if (r_err[56] !== 1'b1) begin errors++; $display("FAIL short_set_beats_clr: got %0b expected 1", r_err[56]); end
        $display("test_short done");
    endtask

    task automatic test_sync();
        int bad, pre_ok, nr;
        logic [1:0] exp_b;
        apply_reset(); clear_stim(); hdmi_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_hs[i] = ((i % 3) == 0);
            s_vs[i] = ((i % 7) < 2);
        end
        set_de(40, 69);
        play(100);
        bad = 0; pre_ok = 0; nr = 0;
        for (int i = 0; i < 100; i++) begin
            exp_b = (i >= 11) ? {s_vs[i-11], s_hs[i-11]} : 2'b00;
            if (r_b[i] !== exp_b) bad++;
            if (i >= 41 && i <= 48 && r_per[i] == P_PRE && r_b[i] === exp_b) pre_ok++;
            if (r_r[i] != 2'b00) nr++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL sync_ctrl_b_delay: got %0d mismatching cycles expected 0", bad); end
        checks++; if (pre_ok != 8) begin errors++; $display("FAIL sync_in_preamble: got %0d good cycles expected 8", pre_ok); end
        checks++; if (nr != 0) begin errors++; $display("FAIL sync_ctrl_r: got %0d nonzero cycles expected 0", nr); end
        $display("test_sync done");
    endtask

    task automatic test_reset_mid();
        int npre, first_vid;
        apply_reset(); clear_stim(); hdmi_en = 1'b1;
        for (int i = 0; i < 30; i++) s_hs[i] = 1'b1;
        set_de(20, 49);
        play(30);
        checks++; if (r_per[29] !== P_GUARD || r_b[29] !== 2'b01) begin errors++; $display("FAIL rmid_before: got period %0d ctrl_b %0b expected 2 01", r_per[29], r_b[29]); end
        de_in = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (period !== P_CTRL || ctrl_b !== 2'b00 || ctrl_g !== 2'b00 || err_short_ctrl !== 1'b0) begin
            errors++; $display("FAIL rmid_immediate: got period %0d ctrl_b %0b ctrl_g %0b err %0b expected 0 00 00 0", period, ctrl_b, ctrl_g, err_short_ctrl);
        end
        de_in = 1'b0; hs_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        clear_stim();
        set_de(20, 49);
        play(80);
        npre = 0; first_vid = -1;
        for (int i = 0; i < 80; i++) begin
            if (r_per[i] == P_PRE) npre++;
            if (first_vid < 0 && r_per[i] == P_VIDEO) first_vid = i;
        end
        checks++; if (npre != 8) begin errors++; $display("FAIL rmid_post_pre: got %0d expected 8", npre); end
        checks++; if (first_vid != 31) begin errors++; $display("FAIL rmid_post_video: got %0d expected 31", first_vid); end
        checks++; if (r_err[79] !== 1'b0) begin errors++; $display("FAIL rmid_post_err: got %0b expected 0", r_err[79]); end
        $display("test_reset_mid done");
    endtask

    initial begin
        reset_n = 1'b0; hdmi_en = 1'b1;
        de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b0; err_clr = 1'b0;
        test_reset();
        test_nominal();
        test_dvi();
        test_marginal();
        test_short();
        test_sync();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
